// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl_if
// Purpose  : Bundles the byte input from the UART receiver, the payload
//            output stream and the frame status outputs of uart_rx_frame_ctrl.
// Ports    : rx_data/rx_vld/rx_error   byte input (receiver -> controller)
//            out_data/out_vld/out_last payload stream, out_ready backpressure
//            pkt_done/pkt_err/err_code frame result, drop_cnt, busy
// Modports : slave  - the frame controller
//            master - the environment driving it
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_ctrl_if #(
    parameter int VLD_DATA_WIDTH = 8
);
    logic [VLD_DATA_WIDTH-1:0] rx_data;
    logic                      rx_vld;
    logic                      rx_error;
    logic [VLD_DATA_WIDTH-1:0] out_data;
    logic                      out_vld;
    logic                      out_ready;
    logic                      out_last;
    logic                      pkt_done;
    logic                      pkt_err;
    logic [1:0]                err_code;
    logic [7:0]                drop_cnt;
    logic                      busy;

    modport slave (
        input  rx_data, rx_vld, rx_error, out_ready,
        output out_data, out_vld, out_last, pkt_done, pkt_err, err_code,
               drop_cnt, busy
    );

    modport master (
        output rx_data, rx_vld, rx_error, out_ready,
        input  out_data, out_vld, out_last, pkt_done, pkt_err, err_code,
               drop_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Purpose  : Assembles HEADER, LEN, payload, CSUM frames from a received byte
//            stream, buffers the payload and releases it on a valid/ready
//            stream only after the checksum verifies. Frames are aborted on
//            parity error, illegal length, checksum mismatch or timeout.
// Ports    : CLK  - system clock (rising edge)
//            rst  - asynchronous active-high reset
//            bus  - uart_rx_frame_ctrl_if.slave (byte in, payload out, status)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter int                        VLD_DATA_WIDTH = 8,
    parameter int                        MAX_LEN        = 16,
    parameter logic [VLD_DATA_WIDTH-1:0] HEADER         = 8'hA5,
    parameter int                        TIMEOUT_CLKS   = 2000
) (
    input  logic                CLK,
    input  logic                rst,
    uart_rx_frame_ctrl_if.slave bus
);
    localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    localparam logic [VLD_DATA_WIDTH-1:0] c_max_len  = VLD_DATA_WIDTH'(MAX_LEN);
    // The counter is compared one step early so the abort is registered on
    // the edge where the count would reach TIMEOUT_CLKS-1.
    localparam logic [TMO_W-1:0]          c_tmo_last = TMO_W'(TIMEOUT_CLKS - 2);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_len   = 3'd1;
    localparam logic [2:0] c_st_pay   = 3'd2;
    localparam logic [2:0] c_st_csum  = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic                      w_abort;
    logic                      w_done;
    logic [1:0]                w_code;
    logic                      w_counting;
    logic                      w_tmo_hit;
    logic                      w_xfer;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W-1:0]          r_last_idx;
    logic [PTR_W-1:0]          w_rd_nxt;
    logic [VLD_DATA_WIDTH-1:0] r_sum;
    logic [VLD_DATA_WIDTH-1:0] r_out_data;
    logic                      r_out_vld;
    logic                      r_out_last;
    logic                      r_pkt_done;
    logic                      r_pkt_err;
    logic [1:0]                r_err_code;
    logic [7:0]                r_drop_cnt;
    logic                      r_busy;
    logic [TMO_W-1:0]          r_tmo;
    logic [VLD_DATA_WIDTH-1:0] r_buf [MAX_LEN];

    assign w_counting = (r_state == c_st_len) || (r_state == c_st_pay) ||
                        (r_state == c_st_csum);
    // A byte arriving on the timeout cycle takes precedence.
    assign w_tmo_hit  = w_counting && !bus.rx_vld && (r_tmo == c_tmo_last);
    assign w_xfer     = r_out_vld && bus.out_ready;
    assign w_rd_nxt   = r_rd_ptr + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        w_code      = 2'd0;
        case (r_state)
            c_st_idle: begin
                if (bus.rx_vld && !bus.rx_error && (bus.rx_data == HEADER))
                    w_state_nxt = c_st_len;
            end
            c_st_len: begin
                if (bus.rx_vld) begin
                    if (bus.rx_error) begin
                        w_abort = 1'b1;
                        w_code  = 2'd0;
                    end else if ((bus.rx_data == '0) || (bus.rx_data > c_max_len)) begin
                        w_abort = 1'b1;
                        w_code  = 2'd1;
                    end else begin
                        w_state_nxt = c_st_pay;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            c_st_pay: begin
                if (bus.rx_vld) begin
                    if (bus.rx_error) begin
                        w_abort = 1'b1;
                        w_code  = 2'd0;
                    end else if (r_wr_ptr == r_last_idx) begin
                        w_state_nxt = c_st_csum;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            c_st_csum: begin
                if (bus.rx_vld) begin
                    if (bus.rx_error) begin
                        w_abort = 1'b1;
                        w_code  = 2'd0;
                    end else if (bus.rx_data != r_sum) begin
                        w_abort = 1'b1;
                        w_code  = 2'd2;
                    end else begin
                        w_done      = 1'b1;
                        w_state_nxt = c_st_drain;
                    end
                end else if (w_tmo_hit) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            c_st_drain: begin
                if (w_xfer && r_out_last)
                    w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
        if (w_abort)
            w_state_nxt = c_st_idle;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_last_idx <= '0;
            r_sum      <= '0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
            r_pkt_done <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= 2'd0;
            r_drop_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != c_st_idle);
            r_pkt_done <= w_done;
            r_pkt_err  <= w_abort;
            if (w_abort)
                r_err_code <= w_code;

            if (bus.rx_vld || !w_counting || w_abort)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            if ((r_state == c_st_len) && bus.rx_vld) begin
                r_last_idx <= PTR_W'(bus.rx_data - 1'b1);
                r_sum      <= bus.rx_data;
                r_wr_ptr   <= '0;
            end

            if ((r_state == c_st_pay) && bus.rx_vld && !bus.rx_error) begin
                r_sum    <= r_sum + bus.rx_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            // The first payload byte is presented together with pkt_done.
            if (w_done) begin
                r_rd_ptr   <= '0;
                r_out_vld  <= 1'b1;
                r_out_data <= r_buf[0];
                r_out_last <= (r_last_idx == '0);
            end

            if (r_state == c_st_drain) begin
                if (bus.rx_vld && (r_drop_cnt != 8'hFF))
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                if (w_xfer) begin
                    if (r_out_last) begin
                        r_out_vld  <= 1'b0;
                        r_out_last <= 1'b0;
                        r_out_data <= '0;
                    end else begin
                        r_rd_ptr   <= w_rd_nxt;
                        r_out_data <= r_buf[w_rd_nxt];
                        r_out_last <= (w_rd_nxt == r_last_idx);
                    end
                end
            end
        end
    end

    // Payload storage needs no reset: it is only read after being written.
    always_ff @(posedge CLK) begin
        if ((r_state == c_st_pay) && bus.rx_vld && !bus.rx_error)
            r_buf[r_wr_ptr] <= bus.rx_data;
    end

    assign bus.out_data = r_out_data;
    assign bus.out_vld  = r_out_vld;
    assign bus.out_last = r_out_last;
    assign bus.pkt_done = r_pkt_done;
    assign bus.pkt_err  = r_pkt_err;
    assign bus.err_code = r_err_code;
    assign bus.drop_cnt = r_drop_cnt;
    assign bus.busy     = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_frame_ctrl
// Purpose  : Self-checking bench for uart_rx_frame_ctrl. A frame-level
//            reference model fills expectation queues; a monitor pops and
//            compares whenever the controller reports a result or transfers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;
    localparam int T  = 2000;
    localparam int ML = 16;

    logic CLK;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   xfers = 0;
    logic ready_val = 1'b0;
    logic rand_mode = 1'b0;

    uart_rx_frame_ctrl_if #(.VLD_DATA_WIDTH(8)) bus ();

    uart_rx_frame_ctrl #(
        .VLD_DATA_WIDTH(8),
        .MAX_LEN(ML),
        .HEADER(8'hA5),
        .TIMEOUT_CLKS(T)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Sole driver of out_ready: fixed value or random per cycle.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] fr[$];
    bit         in_frame = 0;
    int         last_edge = 0;
    logic [2:0] exp_evt[$];   // {is_err, code}; 3'b000 means verified
    logic [8:0] exp_out[$];   // {last, data}
    logic [7:0] fb[$];
    logic       fe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_byte(input logic [7:0] d, input logic e, input int edge_i);
        int s;
        if (in_frame && (edge_i - last_edge) >= T) begin
            exp_evt.push_back(3'b111);
            in_frame = 0;
        end
        last_edge = edge_i;
        if (!in_frame) begin
            if (!e && d == 8'hA5) begin
                in_frame = 1;
                fr.delete();
            end
            return;
        end
        if (e) begin
            exp_evt.push_back(3'b100);
            in_frame = 0;
            return;
        end
        fr.push_back(d);
        if (fr.size() == 1) begin
            if (d == 8'd0 || d > ML) begin
                exp_evt.push_back(3'b101);
                in_frame = 0;
            end
        end else if (fr.size() == int'(fr[0]) + 2) begin
            s = 0;
            for (int i = 0; i < fr.size() - 1; i++) s += fr[i];
            if ((s % 256) != int'(d)) begin
                exp_evt.push_back(3'b110);
            end else begin
                exp_evt.push_back(3'b000);
                for (int i = 1; i < fr.size() - 1; i++)
                    exp_out.push_back({i == fr.size() - 2, fr[i]});
            end
            in_frame = 0;
        end
    endtask

    // ---------------- driver helpers (phase: 1 time unit after posedge) ----------------
    task automatic send_byte(input logic [7:0] d, input logic e, input bit use_model);
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rx_vld   = 1'b1;
        @(posedge CLK);
        #1;
        bus.rx_vld   = 1'b0;
        bus.rx_error = 1'b0;
        if (use_model) model_byte(d, e, cyc);
    endtask

    task automatic idle(input int n);
        if (in_frame && (cyc + n - last_edge) >= T - 1) begin
            exp_evt.push_back(3'b111);
            in_frame = 0;
        end
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_b(input logic [7:0] d, input logic e);
        fb.push_back(d);
        fe.push_back(e);
    endtask

    task automatic build_good(input int len);
        logic [7:0] b;
        logic [7:0] s;
        fb.delete();
        fe.delete();
        push_b(8'hA5, 0);
        push_b(8'(len), 0);
        s = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            push_b(b, 0);
            s = s + b;
        end
        push_b(s, 0);
    endtask

    task automatic send_fb(input int gmax);
        for (int i = 0; i < fb.size(); i++) begin
            send_byte(fb[i], fe[i], 1);
            if (gmax > 0 && i < fb.size() - 1) idle($urandom_range(0, gmax));
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            @(posedge CLK);
            #1;
            k++;
        end
        check("idle_reached", bus.busy, 0);
    endtask

    task automatic set_frame(input logic [7:0] a, input logic [7:0] b);
        fb.delete();
        fe.delete();
        push_b(a, 0);
        push_b(b, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic       stall;
        logic [8:0] held;
        logic [2:0] got;
        stall = 0;
        held  = '0;
        forever begin
            @(negedge CLK);
            if (rst) begin
                stall = 0;
                continue;
            end
            if (stall)
                check("hold_stable", {bus.out_vld, bus.out_last, bus.out_data}, {1'b1, held});
            if (bus.pkt_done || bus.pkt_err) begin
                check("done_err_exclusive", bus.pkt_done & bus.pkt_err, 0);
                got = {bus.pkt_err, bus.pkt_err ? bus.err_code : 2'b00};
                if (exp_evt.size() == 0) check("pkt_expected", exp_evt.size(), 1);
                else check("pkt_event", got, exp_evt.pop_front());
            end
            if (bus.pkt_done) check("vld_with_done", bus.out_vld, 1);
            if (bus.out_vld) begin
                if (exp_out.size() == 0) check("out_expected", exp_out.size(), 1);
                else if (bus.out_ready) begin
                    check("out_xfer", {bus.out_last, bus.out_data}, exp_out.pop_front());
                    xfers++;
                end
            end
            stall = bus.out_vld && !bus.out_ready;
            held  = {bus.out_last, bus.out_data};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   e0;
        int   x0;
        bit   found;
        int   kind;
        int   p;
        logic [7:0] d;
        rst = 1'b1;
        bus.rx_data  = '0;
        bus.rx_vld   = 1'b0;
        bus.rx_error = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_vld", bus.out_vld, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_status", {bus.out_last, bus.pkt_done, bus.pkt_err, bus.err_code}, 0);
        check("rst_drop_busy", {bus.drop_cnt, bus.busy}, 0);
        rst = 1'b0;
        ready_val = 1'b1;
        idle(2);

        // Good frame, ready held high
        set_frame(8'hA5, 8'h03); push_b(8'h11, 0); push_b(8'h22, 0); push_b(8'h33, 0); push_b(8'h69, 0);
        send_fb(0);
        check("good_done", bus.pkt_done, 1);
        check("good_first", {bus.out_vld, bus.out_last, bus.out_data}, {2'b10, 8'h11});
        idle(1);
        check("good_second", {bus.pkt_done, bus.out_vld, bus.out_last, bus.out_data}, {3'b010, 8'h22});
        idle(1);
        check("good_third", {bus.out_vld, bus.out_last, bus.out_data}, {2'b11, 8'h33});
        idle(1);
        check("good_after", {bus.out_vld, bus.busy}, 0);

        // Backpressure: ready 1,0,0,1 from the first valid cycle
        x0 = xfers;
        set_frame(8'hA5, 8'h03); push_b(8'h11, 0); push_b(8'h22, 0); push_b(8'h33, 0); push_b(8'h69, 0);
        send_fb(0);
        idle(1);
        ready_val = 1'b0;
        idle(1);
        idle(1);
        check("bp_held", {bus.out_vld, bus.out_data}, {1'b1, 8'h22});
        ready_val = 1'b1;
        wait_idle();
        idle(1);
        check("bp_xfer_count", xfers - x0, 3);

        // Checksum error followed by a good frame
        set_frame(8'hA5, 8'h02); push_b(8'h10, 0); push_b(8'h20, 0); push_b(8'h31, 0);
        send_fb(0);
        check("csum_err", {bus.pkt_err, bus.err_code, bus.out_vld}, {1'b1, 2'd2, 1'b0});
        idle(2);
        set_frame(8'hA5, 8'h01); push_b(8'h05, 0); push_b(8'h06, 0);
        send_fb(1);
        wait_idle();
        check("code_held", bus.err_code, 2);

        // Length and parity
        set_frame(8'hA5, 8'h00); send_fb(0);
        check("len_zero", {bus.pkt_err, bus.err_code}, {1'b1, 2'd1});
        idle(1);
        set_frame(8'hA5, 8'h11); send_fb(0);
        check("len_over", {bus.pkt_err, bus.err_code}, {1'b1, 2'd1});
        idle(1);
        build_good(ML); send_fb(0);
        check("len_max_done", bus.pkt_done, 1);
        wait_idle();
        set_frame(8'hA5, 8'h02); push_b(8'hAA, 1); send_fb(0);
        check("parity", {bus.pkt_err, bus.err_code}, {1'b1, 2'd0});
        idle(1);

        // Timeout after silence
        set_frame(8'hA5, 8'h02); push_b(8'h01, 0); send_fb(0);
        e0 = cyc;
        exp_evt.push_back(3'b111);
        in_frame = 0;
        found = 0;
        for (int i = 0; i < T + 20 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (bus.pkt_err) begin
                found = 1;
                check("tmo_latency", cyc - e0, T - 1);
                check("tmo_code", bus.err_code, 3);
            end
        end
        check("tmo_seen", found, 1);
        idle(2);

        // Byte on the timeout cycle wins
        set_frame(8'hA5, 8'h02); push_b(8'h01, 0); send_fb(0);
        idle(T - 2);
        send_byte(8'h07, 0, 1);
        send_byte(8'h0A, 0, 1);
        check("tmo_byte_wins", {bus.pkt_done, bus.pkt_err}, 2'b10);
        wait_idle();

        // Drop counter saturation while stalled in drain
        ready_val = 1'b0;
        idle(1);
        set_frame(8'hA5, 8'h01); push_b(8'h42, 0); push_b(8'h43, 0);
        send_fb(0);
        for (int i = 0; i < 300; i++) begin
            d = (i % 7 == 0) ? 8'hA5 : 8'($urandom);
            send_byte(d, 1'($urandom_range(0, 1)), 0);
            if (i == 9) check("drop_10", bus.drop_cnt, 10);
        end
        check("drop_sat", bus.drop_cnt, 255);
        check("drop_hold_data", {bus.out_vld, bus.out_last, bus.out_data}, {2'b11, 8'h42});
        ready_val = 1'b1;
        wait_idle();

        // Asynchronous reset mid-payload
        set_frame(8'hA5, 8'h04); push_b(8'h01, 0); push_b(8'h02, 0);
        send_fb(0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {bus.out_vld, bus.pkt_done, bus.pkt_err, bus.err_code, bus.busy}, 0);
        check("mid_rst_drop", bus.drop_cnt, 0);
        in_frame = 0;
        fr.delete();
        @(posedge CLK);
        #1;
        rst = 1'b0;
        idle(1);
        build_good(3); send_fb(2);
        wait_idle();

        // Randomised frames with random backpressure
        rand_mode = 1'b1;
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: build_good($urandom_range(1, ML));
                2: begin
                    build_good($urandom_range(1, ML));
                    fb[fb.size() - 1] = fb[fb.size() - 1] ^ 8'($urandom_range(1, 255));
                end
                3: set_frame(8'hA5, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255)));
                4: begin
                    build_good($urandom_range(1, ML));
                    p = $urandom_range(1, fb.size() - 1);
                    fe[p] = 1'b1;
                    while (fb.size() > p + 1) begin
                        void'(fb.pop_back());
                        void'(fe.pop_back());
                    end
                end
                default: begin
                    fb.delete();
                    fe.delete();
                    for (int j = 0; j < $urandom_range(1, 4); j++) begin
                        d = 8'($urandom);
                        if (d == 8'hA5) push_b(d, 1);
                        else push_b(d, 1'($urandom_range(0, 1)));
                    end
                end
            endcase
            send_fb(3);
            wait_idle();
            idle($urandom_range(0, 2));
        end
        rand_mode = 1'b0;
        idle(5);
        check("evt_queue_empty", exp_evt.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Packet-level controller that sits behind the UART receiver. It consumes the byte stream (data, valid pulse, parity error) and assembles frames of the form HEADER, LEN, LEN payload bytes, CSUM. It buffers the payload and releases it on a valid/ready stream only after the checksum verifies. It aborts frames on parity error, bad length, checksum mismatch or inter-byte timeout.

Parameters:
- VLD_DATA_WIDTH, 8, byte width; must match the receiver's data width.
- MAX_LEN, 16, maximum payload bytes; sets buffer depth, legal range 1..255.
- HEADER, 8'hA5, start-of-frame byte.
- TIMEOUT_CLKS, 2000, maximum CLK cycles allowed between bytes inside a frame.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  VLD_DATA_WIDTH  received byte from the UART receiver.
- rx_vld  in  1  one-cycle pulse; rx_data and rx_error are valid in that cycle.
- rx_error  in  1  parity error flag for the byte qualified by rx_vld.
- out_data  out  VLD_DATA_WIDTH  payload byte.
- out_vld  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- out_last  out  1  high with the final payload byte of a frame.
- pkt_done  out  1  one-cycle pulse: frame verified.
- pkt_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause, held until the next pkt_err: 0 parity, 1 length, 2 checksum, 3 timeout.
- drop_cnt  out  8  saturating count of bytes dropped while draining.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; pointers, sum and timeout counter cleared. Reset mid-frame discards the buffer.
- Outputs are registered. An rx_vld byte is acted on at the CLK edge where rx_vld=1.

State machine:
- IDLE:
  - rx_vld with rx_data==HEADER and rx_error=0 -> LEN.
  - Any other byte is dropped silently; no pkt_err.
- LEN:
  - rx_error=1 -> abort, code 0.
  - rx_data==0 or rx_data>MAX_LEN -> abort, code 1.
  - Otherwise store len, set sum=rx_data, wr_ptr=0 -> PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[wr_ptr]; sum+=byte mod 256; wr_ptr+=1.
  - After the byte with wr_ptr==len-1 -> CSUM.
  - rx_error=1 -> abort, code 0.
- CSUM:
  - rx_error=1 -> abort, code 0.
  - rx_data!=sum -> abort, code 2.
  - Otherwise pulse pkt_done next cycle, rd_ptr=0 -> DRAIN.
- DRAIN:
  - out_vld=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1).
  - A transfer occurs on out_vld&&out_ready; rd_ptr+=1.
  - Transfer with out_last=1 -> IDLE; out_vld drops the following cycle.
  - out_data and out_last are held stable while out_ready=0.
  - An rx_vld in DRAIN is dropped; drop_cnt+=1, saturating at 255 and never wrapping. A header byte received in DRAIN is dropped as well.
- Abort:
  - pkt_err pulses for 1 cycle; err_code updated in the same cycle; state -> IDLE.
  - Buffer contents are not presented.

Timeout:
- The counter clears on every rx_vld and counts only in LEN, PAYLOAD and CSUM.
- Reaching TIMEOUT_CLKS-1 without a byte -> abort, code 3.
- If rx_vld coincides with the timeout cycle, the byte wins and the timeout is discarded.
- The counter holds at 0 in IDLE and DRAIN.

Other rules:
- Latency: out_vld rises 1 cycle after the CSUM byte edge, the same cycle as pkt_done.
- Checksum: 8-bit modulo sum of LEN plus all payload bytes. HEADER and CSUM are excluded.
- Length MAX_LEN exactly is legal. MAX_LEN+1 is a length error.

Test Plan:
- Good frame: A5,03,11,22,33,69 with out_ready=1 -> pkt_done 1 cycle; out_data 11,22,33 on consecutive cycles; out_last only on 33; busy low after.
- Backpressure: same frame with out_ready toggling 1,0,0,1 -> no byte lost or duplicated; out_data held while ready=0; exactly 3 transfers.
- Checksum error: A5,02,10,20,31 -> pkt_err pulse, err_code=2, out_vld never asserted; following good frame A5,01,05,06 -> out_data 05 with out_last.
- Length and parity: A5,00 -> err_code=1; A5,11 with MAX_LEN=16 -> err_code=1; A5,10 accepted; A5,02,AA with rx_error=1 on AA -> err_code=0.
- Timeout: A5,02,01, then silence of TIMEOUT_CLKS cycles -> pkt_err with err_code=3 at cycle TIMEOUT_CLKS-1 after the last byte. Repeat with a byte arriving exactly on that cycle -> no error.
- Drop and reset: hold out_ready=0 in DRAIN and send 300 bytes -> drop_cnt=255. Assert rst mid-PAYLOAD -> all outputs 0 and IDLE immediately; post-reset good frame passes.
